// File: rtl/viterbi_pkg.sv
// Shared constants for the convolutional encoder and the Viterbi decoder datapath.
// The decoder BMU derives its expected-symbol constants from the same generators.
package viterbi_pkg;
    localparam int K          = 4;
    localparam int NUM_STATES = 8;

    localparam logic [K-1:0] G0_DEF = 4'b1101;
    localparam logic [K-1:0] G1_DEF = 4'b1111;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_e;

    function automatic logic parity(input logic [K-1:0] win, input logic [K-1:0] g);
        return ^(win & g);
    endfunction
endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 symbol generator with the K-1 bit shift register; the newest bit enters at sr[K-2].
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       b_i,
    output logic [1:0] sym_o
);
    logic [K-2:0] sr_q, sr_d;
    logic [K-1:0] win;

    assign win   = {b_i, sr_q};
    assign sym_o = {parity(win, G0), parity(win, G1)};
    assign sr_d  = en_i ? {b_i, sr_q[K-2:1]} : sr_q;

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end
endmodule

// File: rtl/conv_encoder_framer.sv
// Frames information bits, encodes them, and appends K-1 zero tail symbols per frame.
// A single output register with a valid/ready slot; tail cycles never accept input.
module conv_encoder_framer
    import viterbi_pkg::*;
#(
    parameter int           FRAME_LEN = 16,
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF,
    parameter int           CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sym,
    output logic             out_sof,
    output logic             out_eof,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int BW = $clog2(FRAME_LEN + 1);

    enc_state_e       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]       tail_cnt_q, tail_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             vld_q, sof_q, eof_q;
    logic [1:0]       sym_q;

    logic       slot_free, load, enc_b, sof_set, eof_set, last_bit;
    logic [1:0] enc_sym;

    assign slot_free = !vld_q || out_ready;
    assign last_bit  = (bit_cnt_q == BW'(FRAME_LEN - 1));

    conv_enc_core #(.G0(G0), .G1(G1)) u_core (
        .clk  (clk),
        .rst  (rst),
        .en_i (load),
        .b_i  (enc_b),
        .sym_o(enc_sym)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = (FRAME_LEN == 1) ? TAIL : DATA;
            DATA:    if (load && last_bit) state_d = TAIL;
            TAIL:    if (load && eof_set) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        load     = 1'b0;
        enc_b    = 1'b0;
        sof_set  = 1'b0;
        eof_set  = 1'b0;
        case (state_q)
            IDLE, DATA: begin
                in_ready = slot_free && !rst;
                load     = in_valid && in_ready;
                enc_b    = in_bit;
                sof_set  = (state_q == IDLE);
            end
            TAIL: begin
                load    = slot_free;
                eof_set = (tail_cnt_q == 2'd2);
            end
            default: ;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (load) begin
            case (state_q)
                IDLE: bit_cnt_d = BW'(1);
                DATA: bit_cnt_d = bit_cnt_q + BW'(1);
                TAIL: begin
                    if (eof_set) begin
                        tail_cnt_d  = 2'd0;
                        bit_cnt_d   = '0;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end else begin
                        tail_cnt_d = tail_cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            frame_cnt_q <= '0;
            vld_q       <= 1'b0;
            sym_q       <= 2'b00;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            // Payload only moves on load, so a stalled symbol stays put.
            if (load) begin
                vld_q <= 1'b1;
                sym_q <= enc_sym;
                sof_q <= sof_set;
                eof_q <= eof_set;
            end else if (out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_sym   = sym_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench: a FRAME_LEN=1/CNT_W=2 instance and a FRAME_LEN=4 instance with a symbol scoreboard.
module tb_conv_encoder_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_iv, a_ib, a_ir, a_ov, a_or, a_sof, a_eof;
    logic [1:0] a_sym, a_fc;
    logic       b_rst, b_iv, b_ib, b_ir, b_ov, b_or, b_sof, b_eof;
    logic [1:0] b_sym;
    logic [7:0] b_fc;

    conv_encoder_framer #(.FRAME_LEN(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_bit(a_ib), .in_ready(a_ir),
        .out_valid(a_ov), .out_ready(a_or), .out_sym(a_sym), .out_sof(a_sof),
        .out_eof(a_eof), .frame_cnt(a_fc)
    );

    conv_encoder_framer #(.FRAME_LEN(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_bit(b_ib), .in_ready(b_ir),
        .out_valid(b_ov), .out_ready(b_or), .out_sym(b_sym), .out_sof(b_sof),
        .out_eof(b_eof), .frame_cnt(b_fc)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder with the taps of 15/17 octal written out
    function automatic logic [1:0] menc(input logic b, input logic [2:0] s);
        return {b ^ s[2] ^ s[0], b ^ s[2] ^ s[1] ^ s[0]};
    endfunction

    logic       mon_en = 1'b0;
    logic [2:0] m_sr = 3'b000;
    int         m_cnt = 0;
    logic [3:0] sbq[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_ov && b_or) begin
                if (sbq.size() == 0) chk("sb_extra", {b_sym, b_sof, b_eof}, 4'hf);
                else chk("sb_sym", {28'd0, b_sym, b_sof, b_eof}, {28'd0, sbq.pop_front()});
            end
            if (b_iv && b_ir) begin
                sbq.push_back({menc(b_ib, m_sr), m_cnt == 0, 1'b0});
                m_sr = {b_ib, m_sr[2:1]};
                m_cnt++;
                if (m_cnt == 4) begin
                    for (int t = 0; t < 3; t++) begin
                        sbq.push_back({menc(1'b0, m_sr), 1'b0, t == 2});
                        m_sr = {1'b0, m_sr[2:1]};
                    end
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int gap);
        int n;
        b_iv = 1'b0;
        repeat (gap) step();
        b_iv = 1'b1;
        b_ib = b;
        #1;
        n = 0;
        while (!b_ir && n < 50) begin
            step();
            n++;
        end
        chk("send_tmo", n < 50, 1);
        step();
        b_iv = 1'b0;
    endtask

    task automatic wait_eof_b();
        int n;
        n = 0;
        while (!(b_ov && b_eof) && n < 60) begin
            step();
            n++;
        end
        chk("eof_tmo", n < 60, 1);
    endtask

    logic [1:0] exp_f1 [7];
    logic [1:0] exp_fc [4];
    logic [3:0] f1, f3, f4;

    initial begin
        exp_f1 = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
        exp_fc = '{2'd2, 2'd3, 2'd0, 2'd1};
        f1 = 4'b1101;
        a_rst = 1'b1; a_iv = 1'b0; a_ib = 1'b0; a_or = 1'b1;
        b_rst = 1'b1; b_iv = 1'b0; b_ib = 1'b0; b_or = 1'b1;

        step(); step();
        chk("rst_a_ir", a_ir, 0);
        chk("rst_b_ir", b_ir, 0);
        chk("rst_a_ov", a_ov, 0);
        chk("rst_b_out", {b_ov, b_sym, b_sof, b_eof}, 0);
        chk("rst_fc", {a_fc, b_fc}, 0);
        a_rst = 1'b0; b_rst = 1'b0; mon_en = 1'b1;

        // Impulse through the FRAME_LEN=1 instance
        a_iv = 1'b1; a_ib = 1'b1;
        #1;
        chk("imp_ir", a_ir, 1);
        step(); a_iv = 1'b0;
        chk("imp_s0", {a_ov, a_sym, a_sof, a_eof}, 5'b1_11_1_0);
        chk("imp_tail_ir", a_ir, 0);
        step(); chk("imp_s1", {a_ov, a_sym, a_sof, a_eof}, 5'b1_11_0_0);
        step(); chk("imp_s2", {a_ov, a_sym, a_sof, a_eof}, 5'b1_01_0_0);
        step(); chk("imp_s3", {a_ov, a_sym, a_sof, a_eof}, 5'b1_11_0_1);
        chk("imp_fc", a_fc, 1);
        chk("imp_sr", dut_a.u_core.sr_q, 0);
        step(); chk("imp_idle_ov", a_ov, 0);

        // Frame counter wrap with CNT_W=2
        for (int i = 0; i < 4; i++) begin
            a_iv = 1'b1; a_ib = i[0];
            step(); a_iv = 1'b0;
            step(); step(); step();
            chk("wrap_eof", a_eof, 1);
            chk("wrap_fc", a_fc, exp_fc[i]);
        end

        // FRAME_LEN=4, bits 1,0,1,1
        b_iv = 1'b1; b_ib = f1[0];
        for (int i = 0; i < 7; i++) begin
            step();
            if (i < 3) b_ib = f1[i+1];
            else       b_iv = 1'b0;
            chk("f1_sym", b_sym, exp_f1[i]);
            chk("f1_sof", b_sof, i == 0);
            chk("f1_eof", b_eof, i == 6);
            if (i >= 3 && i <= 5) chk("f1_tail_ir", b_ir, 0);
        end
        chk("f1_fc", b_fc, 1);

        // Backpressure after two bits of frame 0,1,1,0
        b_iv = 1'b1; b_ib = 1'b0;
        step(); chk("bp_s0", {b_sym, b_sof}, 3'b00_1);
        b_ib = 1'b1;
        step(); chk("bp_s1", {b_sym, b_sof}, 3'b11_0);
        b_or = 1'b0; b_ib = 1'b1;
        #1;
        chk("bp_ir0", b_ir, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {b_ov, b_sym, b_sof, b_eof, b_ir}, 6'b1_11_0_0_0);
        end
        b_or = 1'b1;
        #1;
        chk("bp_ir1", b_ir, 1);
        step(); chk("bp_s2", b_sym, 2'b00);
        b_ib = 1'b0;
        step(); chk("bp_s3", b_sym, 2'b10);
        b_iv = 1'b0;
        step(); chk("bp_t0", b_sym, 2'b10);
        step(); chk("bp_t1", b_sym, 2'b11);
        step(); chk("bp_t2", {b_sym, b_eof}, 3'b00_1);
        chk("bp_fc", b_fc, 2);

        // Back-to-back frames with random input gaps
        f3 = 4'($urandom);
        f4 = 4'($urandom) | 4'b0001;
        for (int i = 0; i < 4; i++) send_bit(f3[i], int'($urandom_range(0, 2)));
        b_iv = 1'b1; b_ib = f4[0];
        step(); step(); step();
        chk("b2b_eof", b_eof, 1);
        chk("b2b_fc", b_fc, 3);
        step(); b_iv = 1'b0;
        chk("b2b_nobubble", {b_ov, b_sym, b_sof}, 4'b1_11_1);
        for (int i = 1; i < 4; i++) send_bit(f4[i], int'($urandom_range(0, 3)));
        wait_eof_b();
        chk("b2b_fc2", b_fc, 4);

        // Reset after two of four bits
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        mon_en = 1'b0;
        b_rst = 1'b1;
        step();
        chk("mrst_ov", b_ov, 0);
        chk("mrst_fc", b_fc, 0);
        chk("mrst_ir", b_ir, 0);
        b_rst = 1'b0;
        sbq.delete();
        m_sr = 3'b000;
        m_cnt = 0;
        mon_en = 1'b1;
        b_iv = 1'b1; b_ib = 1'b1;
        #1;
        chk("mrst_ir1", b_ir, 1);
        step(); b_iv = 1'b0;
        chk("mrst_s0", {b_ov, b_sym, b_sof}, 4'b1_11_1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 0);
        send_bit(1'b1, 2);
        wait_eof_b();
        chk("mrst_fc1", b_fc, 1);
        step(); step();
        chk("sb_drain", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
